jedro_1_dmem_responder: RTL and testbench
=========================================

JEDRO_1_DMEM_RESPONDER -- requirements
Module: jedro_1_dmem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width in bits.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, memory depth in words; must be a power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra cycles (0..15) inserted before each response.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_i, input, 1, request valid from core.
REQ-008 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-009 SHALL have port we_i, input, DATA_WIDTH/8, byte write enables; all-zero means read.
REQ-010 SHALL have port addr_i, input, ADDR_WIDTH, byte address.
REQ-011 SHALL have port wdata_i, input, DATA_WIDTH, write data.
REQ-012 SHALL have port rvalid_o, output, 1, one-cycle response strobe.
REQ-013 SHALL have port rdata_o, output, DATA_WIDTH, read data, valid only with rvalid_o.
REQ-014 SHALL have port err_o, output, 1, error flag, valid only with rvalid_o.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL assert gnt_o combinationally when req_i=1 and state is IDLE or RESP.
REQ-017 SHALL capture addr_i, we_i and wdata_i on each grant cycle.
REQ-018 SHALL transition on grant to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else to RESP.
REQ-019 SHALL decrement the counter in WAIT and enter RESP when it reaches 0; grant latency to rvalid_o is WAIT_STATES+1 cycles.
REQ-020 SHALL drive rvalid_o=1 for exactly one cycle in RESP, then go to IDLE, or to WAIT/RESP if a new grant occurs in that same cycle (back-to-back, no bubble).
REQ-021 SHALL use word index addr[log2(DEPTH_WORDS)+1:2] and ignore addr[1:0].
REQ-022 SHALL commit a write in the RESP cycle, updating only the bytes whose we bit is set, and return rdata_o=0.
REQ-023 SHALL return the full stored word on rdata_o for reads.
REQ-024 SHALL ensure a read granted in the RESP cycle of a write to the same word returns the newly written data.
REQ-025 SHALL ignore req_i while in WAIT, keeping gnt_o=0 and leaving captured state unchanged.

Reset
REQ-026 SHALL, on rst_i=1, immediately force state to IDLE, counter to 0 and gnt_o, rvalid_o, err_o and rdata_o to 0.
REQ-027 SHALL, on reset during WAIT or RESP, drop the pending transaction with no write committed and no response issued.
REQ-028 SHALL leave memory contents unaffected by reset; they are undefined at power-up unless preloaded by the bench.

Configuration
REQ-029 SHALL, with JEDRO_1_DMEM_ERR_EN defined, treat any address with byte index >= DEPTH_WORDS*4 as out of range: suppress the write, set rdata_o=0 and pulse err_o=1 with rvalid_o.
REQ-030 SHALL, without JEDRO_1_DMEM_ERR_EN, tie err_o to 0 and discard upper address bits so that accesses wrap modulo DEPTH_WORDS.

Structure
REQ-031 SHALL place the FSM state enum and the WAIT_STATES counter width constant in the shared package jedro_1_defines.
REQ-032 SHALL place the storage array and byte-enable write logic in sub-module jedro_1_dmem_array.

Verification
REQ-033 SHALL verify, with WAIT_STATES=1: write 0xDEADBEEF to 0x10 with we=4'hF, then read 0x10 -> rvalid_o 2 cycles after each grant and rdata_o=0xDEADBEEF.
REQ-034 SHALL verify a partial write: 0x11223344 at 0x20, then we=4'b0010 with 0x0000AA00 -> read of 0x20 returns 0x1122AA44.
REQ-035 SHALL verify, with WAIT_STATES=0, back-to-back reads of 0x0, 0x4, 0x8 with req_i held high -> gnt_o high every cycle and rvalid_o high 3 consecutive cycles.
REQ-036 SHALL verify that req_i held during WAIT with WAIT_STATES=3 -> gnt_o=0 for 3 cycles, then grants in RESP.
REQ-037 SHALL verify with the macro defined, DEPTH_WORDS=1024: write to 0x1000 -> err_o=1, and a read of 0x0 is unchanged; without the macro the same write lands at 0x0.
REQ-038 SHALL verify that rst_i asserted during WAIT of a write to 0x30 -> no rvalid_o, and a later read of 0x30 returns the old value.

Source files
------------

// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 data-memory responder: FSM state encoding
// and the width of the wait-state counter.
package jedro_1_defines;

  // Wide enough for WAIT_STATES up to 15.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/jedro_1_dmem_array.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
// Contents are not reset.
module jedro_1_dmem_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/jedro_1_dmem_responder.sv
// Single-port data-memory responder with configurable wait states and back-to-back
// grants from the response cycle. Define JEDRO_1_DMEM_ERR_EN to flag out-of-range accesses.
module jedro_1_dmem_responder
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BE_W-1:0]       we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  gnt, in_resp, is_wr, oor, commit;
  logic                  unused_addr;

  // Grants are possible from IDLE and from RESP, which gives bubble-free pipelining.
  assign gnt   = req_i & ~rst_i & (state_q != ST_WAIT);
  assign gnt_o = gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: ;
    endcase
    if (gnt) begin
      if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_INIT;
      end else begin
        state_d = ST_RESP;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt) begin
        addr_q  <= addr_i;
        we_q    <= we_i;
        wdata_q <= wdata_i;
      end
    end
  end

`ifdef JEDRO_1_DMEM_ERR_EN
  assign oor = (addr_q >> (IDX_W + 2)) != '0;
`else
  // Upper address bits are dropped, so accesses wrap modulo the depth.
  assign oor = 1'b0;
`endif

  assign unused_addr = ^addr_q;
  assign in_resp     = (state_q == ST_RESP);
  assign is_wr       = |we_q;
  assign commit      = in_resp & is_wr & ~oor;

  jedro_1_dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (commit),
    .be_i   (we_q),
    .idx_i  (addr_q[IDX_W+1:2]),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  assign rvalid_o = in_resp;
  assign err_o    = in_resp & oor;
  assign rdata_o  = (in_resp && !is_wr && !oor) ? mem_rdata : '0;

endmodule

// File: tb/tb_jedro_1_dmem_responder.sv
// Self-checking bench: three responders (WAIT_STATES 1, 0, 3) driven from vector
// tables and short sequences, with responses checked against a queue of expectations.
module tb_jedro_1_dmem_responder;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        req    [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [3:0]  we     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   WS [3] = '{1, 0, 3};
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jedro_1_dmem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  jedro_1_dmem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  jedro_1_dmem_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rvalid[k] === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].k != k) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rvalid: inst %0d at cycle %0d, none expected", k, cyc);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("rdata inst%0d", k), rdata[k], e.rdata);
          chk($sformatf("err inst%0d", k), {31'b0, err[k]}, {31'b0, e.err});
          chk($sformatf("latency inst%0d", k), cyc, e.cyc);
        end
      end
    end
  end

  // Present a request at a falling edge and hold it until granted.
  task automatic do_req(input int k, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input bit push, output int waited);
    exp_t e;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    waited = 0;
    #1;
    while (gnt[k] !== 1'b1 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (gnt[k] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: inst %0d got no grant, required one within 40 cycles", k);
    end else if (push) begin
      e.k = k; e.rdata = er; e.err = ee; e.cyc = cyc + 1 + WS[k];
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0; we[k] = 4'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [14];
    int   w;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 4'h0; addr[k] = '0; wdata[k] = '0;
    end
    req[0] = 1'b1; we[0] = 4'hF; wdata[0] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("reset gnt", {31'b0, gnt[0]}, 32'h0);
    chk("reset rvalid", {31'b0, rvalid[0]}, 32'h0);
    chk("reset err", {31'b0, err[0]}, 32'h0);
    chk("reset rdata", rdata[0], 32'h0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      idle(k);
    end
    repeat (2) @(negedge clk);

    // WAIT_STATES=1: full/partial writes, ignored low address bits, wrap/error.
    tbl[0]  = '{4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{4'hF, 32'h20,   32'h11223344, 32'h0,        1'b0};
    tbl[3]  = '{4'h2, 32'h20,   32'h0000AA00, 32'h0,        1'b0};
    tbl[4]  = '{4'h0, 32'h20,   32'h0,        32'h1122AA44, 1'b0};
    tbl[5]  = '{4'hF, 32'h13,   32'hCAFEF00D, 32'h0,        1'b0};
    tbl[6]  = '{4'h0, 32'h12,   32'h0,        32'hCAFEF00D, 1'b0};
    tbl[7]  = '{4'hF, 32'h30,   32'h55667788, 32'h0,        1'b0};
    tbl[8]  = '{4'h8, 32'h30,   32'h99000000, 32'h0,        1'b0};
    tbl[9]  = '{4'h0, 32'h30,   32'h0,        32'h99667788, 1'b0};
    tbl[10] = '{4'hF, 32'h0,    32'h0BADF00D, 32'h0,        1'b0};
`ifdef JEDRO_1_DMEM_ERR_EN
    tbl[11] = '{4'hF, 32'h1000, 32'h12345678, 32'h0,        1'b1};
    tbl[12] = '{4'h0, 32'h0,    32'h0,        32'h0BADF00D, 1'b0};
    tbl[13] = '{4'h0, 32'h1000, 32'h0,        32'h0,        1'b1};
`else
    tbl[11] = '{4'hF, 32'h1000, 32'h12345678, 32'h0,        1'b0};
    tbl[12] = '{4'h0, 32'h0,    32'h0,        32'h12345678, 1'b0};
    tbl[13] = '{4'h0, 32'h1000, 32'h0,        32'h12345678, 1'b0};
`endif
    for (int i = 0; i < 14; i++)
      do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err, 1'b1, w);
    idle(0);
    drain();

    // WAIT_STATES=0: back-to-back with req held, grant every cycle.
    do_req(1, 4'hF, 32'h0, 32'hA0A0A0A0, 32'h0, 1'b0, 1'b1, w);
    do_req(1, 4'hF, 32'h4, 32'hA4A4A4A4, 32'h0, 1'b0, 1'b1, w);
    do_req(1, 4'hF, 32'h8, 32'hA8A8A8A8, 32'h0, 1'b0, 1'b1, w);
    do_req(1, 4'h0, 32'h0, 32'h0, 32'hA0A0A0A0, 1'b0, 1'b1, w);
    chk("b2b gnt wait rd0", w, 0);
    do_req(1, 4'h0, 32'h4, 32'h0, 32'hA4A4A4A4, 1'b0, 1'b1, w);
    chk("b2b gnt wait rd4", w, 0);
    do_req(1, 4'h0, 32'h8, 32'h0, 32'hA8A8A8A8, 1'b0, 1'b1, w);
    chk("b2b gnt wait rd8", w, 0);
    // Read granted in the commit cycle of a write to the same word.
    do_req(1, 4'hF, 32'h40, 32'h76543210, 32'h0, 1'b0, 1'b1, w);
    do_req(1, 4'h0, 32'h40, 32'h0, 32'h76543210, 1'b0, 1'b1, w);
    chk("b2b raw gnt wait", w, 0);
    idle(1);
    drain();

    // WAIT_STATES=3: request held through WAIT is only granted in RESP.
    do_req(2, 4'hF, 32'h30, 32'h11111111, 32'h0, 1'b0, 1'b1, w);
    do_req(2, 4'h0, 32'h30, 32'h0, 32'h11111111, 1'b0, 1'b1, w);
    chk("ws3 held-req wait cycles", w, 3);
    idle(2);
    drain();

    // Reset in WAIT drops the write and its response.
    do_req(2, 4'hF, 32'h30, 32'h22222222, 32'h0, 1'b0, 1'b0, w);
    idle(2);
    rst[2] = 1'b1;
    req[2] = 1'b1;
    #1;
    chk("rst-in-wait gnt", {31'b0, gnt[2]}, 32'h0);
    chk("rst-in-wait rvalid", {31'b0, rvalid[2]}, 32'h0);
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    idle(2);
    repeat (6) @(negedge clk);
    do_req(2, 4'h0, 32'h30, 32'h0, 32'h11111111, 1'b0, 1'b1, w);
    idle(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
